regbank16_8w: RTL and testbench

//   Write side of the 8 x 16-bit general register bank. Accepts one write per cycle
//   (valid/ready), decodes the 3-bit destination to one-hot and commits data with byte

---
 rtl/regbank_pkg.sv | 25 ++
 rtl/dec3_8.sv | 18 +
 rtl/regbank16_8w.sv | 147 ++++++++++++++
 tb/tb_regbank16_8w.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regbank_pkg.sv
// Shared constants and types for the 8 x 16-bit register bank write side.
// Imported by the decoder and the top level.
package regbank_pkg;

    localparam int NREG  = 8;
    localparam int WIDTH = 16;
    localparam int SEL_W = 3;

    localparam int BE_LO = 0;
    localparam int BE_HI = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Write captured at acceptance, committed one edge later.
    typedef struct packed {
        logic             vld;
        logic [SEL_W-1:0] sel;
        logic [WIDTH-1:0] data;
        logic [1:0]       be;
    } stage_t;

endpackage

// File: rtl/dec3_8.sv
// 3-bit index to one-hot decoder with enable.
// Output is all-zero when en is low.
module dec3_8
    import regbank_pkg::*;
(
    input  logic [SEL_W-1:0] idx,
    input  logic             en,
    output logic [NREG-1:0]  oh
);

    always_comb begin
        oh = '0;
        if (en) begin
            oh = NREG'(1) << idx;
        end
    end

endmodule

// File: rtl/regbank16_8w.sv
// Write side of the 8 x 16-bit register bank: staged byte-enabled
// writes with valid/ready, plus an 8-edge sequential clear.
module regbank16_8w #(
    parameter int WIDTH   = 16,
    parameter bit ZERO_R0 = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2:0]       wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [1:0]       wr_be,
    input  logic             clr_req,
    output logic             busy,
    output logic             wr_done,
    output logic [WIDTH-1:0] r0,
    output logic [WIDTH-1:0] r1,
    output logic [WIDTH-1:0] r2,
    output logic [WIDTH-1:0] r3,
    output logic [WIDTH-1:0] r4,
    output logic [WIDTH-1:0] r5,
    output logic [WIDTH-1:0] r6,
    output logic [WIDTH-1:0] r7
);

    import regbank_pkg::*;

    state_t           state;
    state_t           state_nx;
    logic [SEL_W-1:0] clr_cnt;
    logic             clr_en;
    logic             accept;
    stage_t           stg;

    logic [NREG-1:0]      wr_oh;
    logic [NREG-1:0]      clr_oh;
    logic [NREG-1:0][1:0] lane_we;
    logic [WIDTH-1:0]     r [NREG];

    assign accept = wr_valid & wr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (clr_req)          state_nx = ST_CLEAR;
            ST_CLEAR: if (clr_cnt == 3'd7)  state_nx = ST_IDLE;
            default:                        state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == ST_CLEAR);
        clr_en   = (state == ST_CLEAR);
        wr_ready = (state == ST_IDLE) && !clr_req && rst_n;
    end

    // Held at 0 in IDLE so the entry edge leaves it ready for r0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_cnt <= '0;
        end else if (state == ST_IDLE) begin
            clr_cnt <= '0;
        end else begin
            clr_cnt <= clr_cnt + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg <= '0;
        end else begin
            stg.vld <= accept;
            if (accept) begin
                stg.sel  <= wr_sel;
                stg.data <= wr_data;
                stg.be   <= wr_be;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_done <= 1'b0;
        end else begin
            wr_done <= stg.vld;
        end
    end

    dec3_8 u_dec_wr (
        .idx (stg.sel),
        .en  (stg.vld),
        .oh  (wr_oh)
    );

    dec3_8 u_dec_clr (
        .idx (clr_cnt),
        .en  (clr_en),
        .oh  (clr_oh)
    );

    always_comb begin
        lane_we = '0;
        for (int i = 0; i < NREG; i++) begin
            lane_we[i][BE_LO] = wr_oh[i] & stg.be[BE_LO];
            lane_we[i][BE_HI] = wr_oh[i] & stg.be[BE_HI];
        end
        if (ZERO_R0) begin
            lane_we[0] = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (clr_oh[i]) begin
                    r[i] <= '0;
                end else begin
                    if (lane_we[i][BE_LO]) r[i][7:0]  <= stg.data[7:0];
                    if (lane_we[i][BE_HI]) r[i][15:8] <= stg.data[15:8];
                end
            end
        end
    end

    assign r0 = r[0];
    assign r1 = r[1];
    assign r2 = r[2];
    assign r3 = r[3];
    assign r4 = r[4];
    assign r5 = r[5];
    assign r6 = r[6];
    assign r7 = r[7];

endmodule

// File: tb/tb_regbank16_8w.sv
// Bench for regbank16_8w: directed scenarios plus a randomized run against
// a register-array reference model, with ZERO_R0=0 (ua) and =1 (ub).
module tb_regbank16_8w;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic [2:0]  wr_sel;
    logic [15:0] wr_data;
    logic [1:0]  wr_be;
    logic        clr_req;

    logic        a_ready, a_busy, a_done;
    logic        b_ready, b_busy, b_done;
    logic [15:0] a0, a1, a2, a3, a4, a5, a6, a7;
    logic [15:0] b0, b1, b2, b3, b4, b5, b6, b7;
    logic [15:0] ra [8];
    logic [15:0] rb [8];

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    logic [15:0] m0 [8];
    logic [15:0] m1 [8];
    logic        pv;
    logic [2:0]  ps;
    logic [15:0] pd;
    logic [1:0]  pb;
    int          cp;
    logic        exp_rdy, exp_done, exp_busy;
    logic        rdy_a, rdy_b;

    always #5 clk = ~clk;

    assign ra = '{a0, a1, a2, a3, a4, a5, a6, a7};
    assign rb = '{b0, b1, b2, b3, b4, b5, b6, b7};

    regbank16_8w #(.WIDTH(16), .ZERO_R0(1'b0)) ua (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(a_ready),
        .wr_sel(wr_sel), .wr_data(wr_data), .wr_be(wr_be), .clr_req(clr_req),
        .busy(a_busy), .wr_done(a_done),
        .r0(a0), .r1(a1), .r2(a2), .r3(a3), .r4(a4), .r5(a5), .r6(a6), .r7(a7)
    );

    regbank16_8w #(.WIDTH(16), .ZERO_R0(1'b1)) ub (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(b_ready),
        .wr_sel(wr_sel), .wr_data(wr_data), .wr_be(wr_be), .clr_req(clr_req),
        .busy(b_busy), .wr_done(b_done),
        .r0(b0), .r1(b1), .r2(b2), .r3(b3), .r4(b4), .r5(b5), .r6(b6), .r7(b7)
    );

    // One clock: drive inputs, note ready before the edge, advance the model.
    task automatic cyc(input logic v, input logic [2:0] s, input logic [15:0] d,
                       input logic [1:0] be, input logic c);
        logic acc;
        wr_valid = v; wr_sel = s; wr_data = d; wr_be = be; clr_req = c;
        #1;
        rdy_a   = a_ready;
        rdy_b   = b_ready;
        exp_rdy = rst_n && (cp < 0) && !c;
        acc     = v && exp_rdy;
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin m0[i] = 0; m1[i] = 0; end
            pv = 0; cp = -1; exp_done = 0;
        end else begin
            exp_done = pv;
            if (pv) begin
                if (pb[0]) m0[ps][7:0]  = pd[7:0];
                if (pb[1]) m0[ps][15:8] = pd[15:8];
                if (ps != 0) m1[ps] = m0[ps];
            end
            if (cp >= 0) begin
                m0[cp] = 0; m1[cp] = 0;
                cp = (cp == 7) ? -1 : cp + 1;
            end else if (c) begin
                cp = 0;
            end
            pv = acc; ps = s; pd = d; pb = be;
        end
        exp_busy = (cp >= 0);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 3'd0, 16'h0, 2'b00, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 0; idle(); idle(); rst_n = 1;
        cyc(1, 3, 16'h1234, 2'b11, 0); idle();
        n_cmp++; if (ra[3] !== 16'h1234) begin n_bad++;
            $display("FAIL reset_preload r3 got %h want 1234", ra[3]); end
        cyc(0, 0, 0, 0, 1); idle(); idle(); idle();
        n_cmp++; if (a_busy !== 1'b1) begin n_bad++;
            $display("FAIL reset_midclear busy got %b want 1", a_busy); end
        rst_n = 0; idle();
        n_cmp++; if (rdy_a !== 1'b0) begin n_bad++;
            $display("FAIL reset_ready_in_rst got %b want 0", rdy_a); end
        idle(); rst_n = 1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (ra[i] !== 16'h0 || rb[i] !== 16'h0) begin n_bad++;
                $display("FAIL reset_reg r%0d got %h/%h want 0", i, ra[i], rb[i]); end
        end
        n_cmp++; if (a_busy !== 1'b0 || a_done !== 1'b0) begin n_bad++;
            $display("FAIL reset_flags busy/done got %b%b want 00", a_busy, a_done); end
        #1;
        n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin n_bad++;
            $display("FAIL reset_ready got %b%b want 11", a_ready, b_ready); end
    endtask

    task automatic test_byte_enable();
        cyc(1, 5, 16'hBEEF, 2'b11, 0);
        n_cmp++; if (rdy_a !== 1'b1) begin n_bad++;
            $display("FAIL be_ready got %b want 1", rdy_a); end
        cyc(1, 5, 16'h00AA, 2'b01, 0);
        n_cmp++; if (ra[5] !== 16'hBEEF || a_done !== 1'b1) begin n_bad++;
            $display("FAIL be_first r5/done got %h/%b want BEEF/1", ra[5], a_done); end
        idle();
        n_cmp++; if (ra[5] !== 16'hBEAA || rb[5] !== 16'hBEAA || a_done !== 1'b1) begin
            n_bad++;
            $display("FAIL be_second r5/done got %h/%b want BEAA/1", ra[5], a_done); end
        idle();
        n_cmp++; if (a_done !== 1'b0) begin n_bad++;
            $display("FAIL be_done_low got %b want 0", a_done); end
    endtask

    task automatic test_back_to_back();
        int ndone = 0;
        int nrdy = 0;
        for (int i = 0; i < 8; i++) begin
            cyc(1, 3'(i), 16'h1000 + 16'(i), 2'b11, 0);
            if (rdy_a === 1'b1) nrdy++;
            if (a_done === 1'b1) ndone++;
        end
        idle();
        if (a_done === 1'b1) ndone++;
        idle();
        n_cmp++; if (nrdy != 8) begin n_bad++;
            $display("FAIL b2b_ready cycles got %0d want 8", nrdy); end
        n_cmp++; if (ndone != 8 || a_done !== 1'b0) begin n_bad++;
            $display("FAIL b2b_done cycles got %0d want 8", ndone); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (ra[i] !== 16'h1000 + 16'(i) ||
                rb[i] !== ((i == 0) ? 16'h0 : 16'h1000 + 16'(i))) begin
                n_bad++;
                $display("FAIL b2b_reg r%0d got %h/%h want %h", i, ra[i], rb[i],
                         16'h1000 + 16'(i));
            end
        end
    endtask

    task automatic test_clr_vs_write();
        int nbusy = 0;
        cyc(1, 2, 16'h5555, 2'b11, 0); idle();
        n_cmp++; if (ra[2] !== 16'h5555) begin n_bad++;
            $display("FAIL cvw_preload r2 got %h want 5555", ra[2]); end
        cyc(1, 2, 16'hAAAA, 2'b11, 1);
        n_cmp++; if (rdy_a !== 1'b0 || ra[2] !== 16'h5555) begin n_bad++;
            $display("FAIL cvw_entry ready/r2 got %b/%h want 0/5555", rdy_a, ra[2]); end
        if (a_busy === 1'b1) nbusy++;
        for (int k = 0; k < 8; k++) begin
            cyc(1, 3'($urandom_range(0, 7)), 16'($urandom), 2'b11, 0);
            n_cmp++; if (rdy_a !== 1'b0 || a_done !== 1'b0) begin n_bad++;
                $display("FAIL cvw_blocked k%0d ready/done got %b%b want 00", k, rdy_a, a_done); end
            n_cmp++; if (ra[k] !== 16'h0) begin n_bad++;
                $display("FAIL cvw_order r%0d got %h want 0", k, ra[k]); end
            if (k < 7) begin
                n_cmp++; if (ra[k+1] === 16'h0) begin n_bad++;
                    $display("FAIL cvw_early r%0d got 0 want nonzero", k + 1); end
            end
            if (a_busy === 1'b1) nbusy++;
        end
        n_cmp++; if (nbusy != 8 || a_busy !== 1'b0) begin n_bad++;
            $display("FAIL cvw_busy cycles got %0d want 8", nbusy); end
        n_cmp++; if (ra[2] !== 16'h0) begin n_bad++;
            $display("FAIL cvw_r2 got %h want 0", ra[2]); end
        idle();
    endtask

    task automatic test_write_then_clear();
        cyc(1, 0, 16'h00FF, 2'b11, 0);
        cyc(0, 0, 0, 0, 1);
        n_cmp++; if (ra[0] !== 16'h00FF || rb[0] !== 16'h0 || a_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL wtc_entry r0/busy got %h/%b want 00FF/1", ra[0], a_busy); end
        idle();
        n_cmp++; if (ra[0] !== 16'h0) begin n_bad++;
            $display("FAIL wtc_cleared r0 got %h want 0", ra[0]); end
        for (int k = 0; k < 7; k++) idle();
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++;
            $display("FAIL wtc_exit busy got %b want 0", a_busy); end
    endtask

    task automatic test_zero_r0();
        cyc(1, 0, 16'hFFFF, 2'b11, 0); idle();
        n_cmp++; if (b_done !== 1'b1 || rb[0] !== 16'h0 || ra[0] !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL zr0_r0 done/r0 got %b/%h want 1/0000", b_done, rb[0]); end
        cyc(1, 1, 16'hFFFF, 2'b11, 0); idle();
        n_cmp++; if (rb[1] !== 16'hFFFF || b_done !== 1'b1) begin n_bad++;
            $display("FAIL zr0_r1 r1 got %h want FFFF", rb[1]); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            cyc($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 16'($urandom),
                2'($urandom_range(0, 3)), $urandom_range(0, 19) == 0);
            n_cmp++; if (rdy_a !== exp_rdy || rdy_b !== exp_rdy) begin n_bad++;
                $display("FAIL rnd_ready n%0d got %b%b want %b", n, rdy_a, rdy_b, exp_rdy); end
            n_cmp++;
            if (a_busy !== exp_busy || b_busy !== exp_busy ||
                a_done !== exp_done || b_done !== exp_done) begin
                n_bad++;
                $display("FAIL rnd_flags n%0d busy %b%b done %b%b want %b/%b", n,
                         a_busy, b_busy, a_done, b_done, exp_busy, exp_done);
            end
            for (int i = 0; i < 8; i++) begin
                n_cmp++; if (ra[i] !== m0[i] || rb[i] !== m1[i]) begin n_bad++;
                    $display("FAIL rnd_reg n%0d r%0d got %h/%h want %h/%h", n, i,
                             ra[i], rb[i], m0[i], m1[i]); end
            end
        end
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0; wr_valid = 0; wr_sel = 0; wr_data = 0; wr_be = 0; clr_req = 0;
        pv = 0; ps = 0; pd = 0; pb = 0; cp = -1;
        exp_rdy = 0; exp_done = 0; exp_busy = 0; rdy_a = 0; rdy_b = 0;
        for (int i = 0; i < 8; i++) begin m0[i] = 0; m1[i] = 0; end
        test_reset();
        test_byte_enable();
        test_back_to_back();
        test_clr_vs_write();
        test_write_then_clear();
        test_zero_r0();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
